// File: rtl/synth_pkg.sv
// Shared constants and state encodings for the voice sequencer.
package synth_pkg;

  localparam int NUM_KEYS = 128;
  localparam int KEY_W    = 7;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    V_IDLE   = 2'd0,
    V_ATTACK = 2'd1,
    V_HOLD   = 2'd2
  } voice_state_t;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    WAIT  = 3'd1,
    CLEAR = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/voice_state_mem.sv
// Per-key voice state and gate storage with a scan read/write port and an
// event port; an event on the same key as a scan write takes priority.
module voice_state_mem
  import synth_pkg::*;
#(
  parameter int NUM_KEYS = synth_pkg::NUM_KEYS
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [KEY_W-1:0]    scan_addr,
  input  logic                scan_we,
  input  logic [1:0]          scan_wstate,
  output logic [1:0]          scan_rstate,
  output logic                scan_rgate,
  input  logic [KEY_W-1:0]    evt_addr,
  input  logic                evt_we,
  input  logic                evt_on,
  output logic [NUM_KEYS-1:0] active_next
);

  logic [NUM_KEYS-1:0][1:0] state_all;
  logic [NUM_KEYS-1:0]      gate_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      voice_state_t state_reg, state_next;
      logic         gate_reg, gate_next;

      always_comb begin
        state_next = state_reg;
        gate_next  = gate_reg;
        if (evt_we && evt_addr == KEY_W'(gi)) begin
          gate_next = evt_on;
          if (evt_on)
            state_next = V_ATTACK;
          else if (state_reg == V_ATTACK)
            state_next = V_HOLD;
        end else if (scan_we && scan_addr == KEY_W'(gi)) begin
          state_next = voice_state_t'(scan_wstate);
        end
      end

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          state_reg <= V_IDLE;
          gate_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          gate_reg  <= gate_next;
        end
      end

      assign state_all[gi]   = state_reg;
      assign gate_all[gi]    = gate_reg;
      assign active_next[gi] = (state_next != V_IDLE);
    end
  endgenerate

  assign scan_rstate = state_all[scan_addr];
  assign scan_rgate  = gate_all[scan_addr];

endmodule

// File: rtl/voice_sequencer.sv
// Frame controller: initialises the datapath, then scans every key once per
// sample tick, driving load/select strobes and tracking per-key envelope phase.
module voice_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_KEYS = synth_pkg::NUM_KEYS
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SAMPLE_TICK,
  input  logic       KEY_EVT_VALID,
  output logic       KEY_EVT_READY,
  input  logic [6:0] KEY_EVT_NUM,
  input  logic       KEY_EVT_ON,
  output logic [6:0] KEY,
  output logic       LD_PHASE,
  output logic       LD_AMP,
  output logic       LD_TONE,
  output logic       PHASE_MUX,
  output logic       TONE_MUX,
  output logic       AMP_SEL,
  output logic       ATT_ON,
  output logic       NOTE_ON,
  input  logic       ATT_OFF,
  input  logic       NOTE_END,
  output logic       FRAME_DONE,
  output logic [7:0] VOICES_ACTIVE,
  output logic       OVERRUN
);

  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);

  seq_state_t          state_reg;
  logic [KEY_W-1:0]    key_reg;
  logic                init_ld_reg;
  logic                clr_ld_reg;
  logic                frame_done_reg;
  logic                overrun_reg;
  logic [CNT_W-1:0]    voices_reg;
  logic [CNT_W-1:0]    active_cnt;
  logic [1:0]          scan_rstate_raw;
  voice_state_t        scan_state;
  logic                scan_gate;
  logic                scan_active;
  logic                scan_we;
  logic [1:0]          scan_wstate;
  logic                evt_we;
  logic [NUM_KEYS-1:0] active_next;

  voice_state_mem #(.NUM_KEYS(NUM_KEYS)) u_mem (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .scan_addr   (key_reg),
    .scan_we     (scan_we),
    .scan_wstate (scan_wstate),
    .scan_rstate (scan_rstate_raw),
    .scan_rgate  (scan_gate),
    .evt_addr    (KEY_EVT_NUM),
    .evt_we      (evt_we),
    .evt_on      (KEY_EVT_ON),
    .active_next (active_next)
  );

  assign scan_state  = voice_state_t'(scan_rstate_raw);
  assign evt_we      = KEY_EVT_VALID && KEY_EVT_READY;
  assign scan_active = (state_reg == SCAN) && (scan_state != V_IDLE);
  assign scan_we     = scan_active && (NOTE_END || (scan_state == V_ATTACK && ATT_OFF));
  assign scan_wstate = NOTE_END ? V_IDLE : V_HOLD;

  // Count reflects the last scan write and any same-cycle event.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      active_cnt = active_cnt + CNT_W'(active_next[i]);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= INIT;
      key_reg        <= '0;
      init_ld_reg    <= 1'b0;
      clr_ld_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      voices_reg     <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (SAMPLE_TICK && state_reg != WAIT)
        overrun_reg <= 1'b1;
      case (state_reg)
        // First cycle after reset arms the sweep so no strobe leaks out during reset.
        INIT: begin
          if (!init_ld_reg) begin
            init_ld_reg <= 1'b1;
          end else if (key_reg == LAST_KEY) begin
            init_ld_reg <= 1'b0;
            key_reg     <= '0;
            state_reg   <= WAIT;
          end else begin
            key_reg <= key_reg + KEY_W'(1);
          end
        end
        WAIT: begin
          if (SAMPLE_TICK) begin
            clr_ld_reg <= 1'b1;
            state_reg  <= CLEAR;
          end
        end
        CLEAR: begin
          clr_ld_reg <= 1'b0;
          state_reg  <= SCAN;
        end
        SCAN: begin
          if (key_reg == LAST_KEY) begin
            key_reg        <= '0;
            frame_done_reg <= 1'b1;
            voices_reg     <= active_cnt;
            state_reg      <= DONE;
          end else begin
            key_reg <= key_reg + KEY_W'(1);
          end
        end
        DONE: begin
          frame_done_reg <= 1'b0;
          state_reg      <= WAIT;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  assign KEY           = key_reg;
  assign KEY_EVT_READY = (state_reg != INIT);
  assign LD_PHASE      = init_ld_reg || scan_active;
  assign PHASE_MUX     = scan_active && !NOTE_END;
  assign LD_AMP        = init_ld_reg || scan_active;
  assign AMP_SEL       = init_ld_reg || (scan_active && NOTE_END);
  assign LD_TONE       = clr_ld_reg || scan_active;
  assign TONE_MUX      = scan_active;
  assign ATT_ON        = scan_active && (scan_state == V_ATTACK);
  assign NOTE_ON       = scan_active && scan_gate;
  assign FRAME_DONE    = frame_done_reg;
  assign VOICES_ACTIVE = voices_reg;
  assign OVERRUN       = overrun_reg;

endmodule

// File: tb/tb_voice_sequencer.sv
// Scoreboard bench for voice_sequencer: a key-level envelope model predicts
// every strobe cycle and frame summary; a monitor compares them as they appear.
module tb_voice_sequencer;

  localparam int IDLE = 0;
  localparam int ATK  = 1;
  localparam int HLD  = 2;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       SAMPLE_TICK;
  logic       KEY_EVT_VALID;
  logic       KEY_EVT_READY;
  logic [6:0] KEY_EVT_NUM;
  logic       KEY_EVT_ON;
  logic [6:0] KEY;
  logic       LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL, ATT_ON, NOTE_ON;
  logic       ATT_OFF, NOTE_END;
  logic       FRAME_DONE;
  logic [7:0] VOICES_ACTIVE;
  logic       OVERRUN;

  always #5 CLK = ~CLK;

  voice_sequencer dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .SAMPLE_TICK   (SAMPLE_TICK),
    .KEY_EVT_VALID (KEY_EVT_VALID),
    .KEY_EVT_READY (KEY_EVT_READY),
    .KEY_EVT_NUM   (KEY_EVT_NUM),
    .KEY_EVT_ON    (KEY_EVT_ON),
    .KEY           (KEY),
    .LD_PHASE      (LD_PHASE),
    .LD_AMP        (LD_AMP),
    .LD_TONE       (LD_TONE),
    .PHASE_MUX     (PHASE_MUX),
    .TONE_MUX      (TONE_MUX),
    .AMP_SEL       (AMP_SEL),
    .ATT_ON        (ATT_ON),
    .NOTE_ON       (NOTE_ON),
    .ATT_OFF       (ATT_OFF),
    .NOTE_END      (NOTE_END),
    .FRAME_DONE    (FRAME_DONE),
    .VOICES_ACTIVE (VOICES_ACTIVE),
    .OVERRUN       (OVERRUN)
  );

  // Datapath stand-in: envelope status per key for the current frame.
  logic att_t [128];
  logic end_t [128];
  assign ATT_OFF  = att_t[KEY];
  assign NOTE_END = end_t[KEY];

  // outs = {LD_PHASE, PHASE_MUX, LD_AMP, AMP_SEL, LD_TONE, TONE_MUX, ATT_ON, NOTE_ON}
  typedef struct packed {
    logic [6:0] key;
    logic [7:0] outs;
    logic       fd;
    logic [7:0] va;
  } rec_t;

  rec_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b1;
  int   mst   [128];
  bit   mgate [128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic rec_t mk(input int k, input logic [7:0] o, input logic fd, input int va);
    rec_t r;
    r.key  = 7'(k);
    r.outs = o;
    r.fd   = fd;
    r.va   = 8'(va);
    return r;
  endfunction

  function automatic void apply_event(input int k, input bit on);
    if (on) begin
      mst[k]   = ATK;
      mgate[k] = 1'b1;
    end else begin
      mgate[k] = 1'b0;
      if (mst[k] == ATK) mst[k] = HLD;
    end
  endfunction

  function automatic void clr_tables();
    for (int k = 0; k < 128; k++) begin
      att_t[k] = 1'b0;
      end_t[k] = 1'b0;
    end
  endfunction

  function automatic void rand_tables();
    for (int k = 0; k < 128; k++) begin
      int r;
      r = int'($urandom_range(0, 7));
      end_t[k] = (r == 0);
      att_t[k] = (r == 1 || r == 2);
    end
  endfunction

  // Monitor: every cycle carrying a strobe or FRAME_DONE is one transaction.
  always @(negedge CLK) begin
    logic [7:0] o;
    rec_t       e;
    if (RESET_N && mon_en) begin
      o = {LD_PHASE, PHASE_MUX, LD_AMP, AMP_SEL, LD_TONE, TONE_MUX, ATT_ON, NOTE_ON};
      if (o != 8'd0 || FRAME_DONE) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_output key%0d", KEY), {23'd0, FRAME_DONE, o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("frame_done_flag key%0d", e.key), 32'(FRAME_DONE), 32'(e.fd));
          chk($sformatf("strobes key%0d", e.key), 32'(o), 32'(e.outs));
          if (e.fd) chk("voices_active", 32'(VOICES_ACTIVE), 32'(e.va));
          else      chk("key_index", 32'(KEY), 32'(e.key));
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_event(input int k, input bit on);
    KEY_EVT_NUM   = 7'(k);
    KEY_EVT_ON    = on;
    KEY_EVT_VALID = 1'b1;
    chk("event_ready", 32'(KEY_EVT_READY), 32'd1);
    step();
    KEY_EVT_VALID = 1'b0;
    apply_event(k, on);
    $display("event key=%0d on=%0d", k, on);
  endtask

  task automatic do_init();
    int n;
    bit ready_seen;
    for (int k = 0; k < 128; k++) exp_q.push_back(mk(k, 8'b1011_0000, 1'b0, 0));
    RESET_N    = 1'b1;
    n          = 0;
    ready_seen = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      if (KEY_EVT_READY) ready_seen = 1'b1;
      step();
      n++;
    end
    chk("init_ready_low", 32'(ready_seen), 32'd0);
    chk("init_drained", 32'(exp_q.size()), 32'd0);
    chk("wait_ready_high", 32'(KEY_EVT_READY), 32'd1);
    $display("init sweep done after %0d cycles", n);
  endtask

  // Predicts one frame from the key-level model, then drives the tick.
  task automatic run_frame(input int inj_key, input bit inj_on, input bit second_tick);
    int n;
    int cnt;
    int s;
    bit g;
    logic e;
    exp_q.push_back(mk(0, 8'b0000_1000, 1'b0, 0));
    for (int k = 0; k < 128; k++) begin
      s = mst[k];
      g = mgate[k];
      if (s != IDLE) begin
        e = end_t[k];
        exp_q.push_back(mk(k, {1'b1, ~e, 1'b1, e, 1'b1, 1'b1, (s == ATK), g}, 1'b0, 0));
        if (e) mst[k] = IDLE;
        else if (s == ATK && att_t[k]) mst[k] = HLD;
      end
      if (k == inj_key) begin
        mst[k]   = s;
        mgate[k] = g;
        apply_event(k, inj_on);
      end
    end
    cnt = 0;
    for (int k = 0; k < 128; k++) if (mst[k] != IDLE) cnt++;
    exp_q.push_back(mk(0, 8'd0, 1'b1, cnt));

    SAMPLE_TICK = 1'b1;
    step();
    SAMPLE_TICK = 1'b0;
    n = 1;
    while (!FRAME_DONE && n < 200) begin
      if (inj_key >= 0 && n == inj_key + 2) begin
        chk("inject_key", 32'(KEY), 32'(inj_key));
        KEY_EVT_NUM   = 7'(inj_key);
        KEY_EVT_ON    = inj_on;
        KEY_EVT_VALID = 1'b1;
      end
      if (second_tick && n == 50) SAMPLE_TICK = 1'b1;
      step();
      n++;
      KEY_EVT_VALID = 1'b0;
      SAMPLE_TICK   = 1'b0;
    end
    chk("frame_latency", 32'(n), 32'd130);
    $display("frame done latency=%0d voices=%0d expected_voices=%0d inject=%0d overrun=%0d",
             n, VOICES_ACTIVE, cnt, inj_key, OVERRUN);
    step();
  endtask

  initial begin
    int nev;
    int fd_seen;
    RESET_N       = 1'b0;
    SAMPLE_TICK   = 1'b0;
    KEY_EVT_VALID = 1'b0;
    KEY_EVT_NUM   = 7'd0;
    KEY_EVT_ON    = 1'b0;
    clr_tables();
    for (int k = 0; k < 128; k++) begin
      mst[k]   = IDLE;
      mgate[k] = 1'b0;
    end
    repeat (3) step();
    chk("reset_key", 32'(KEY), 32'd0);
    chk("reset_frame_done", 32'(FRAME_DONE), 32'd0);
    chk("reset_voices", 32'(VOICES_ACTIVE), 32'd0);
    chk("reset_overrun", 32'(OVERRUN), 32'd0);
    chk("reset_ready", 32'(KEY_EVT_READY), 32'd0);
    chk("reset_strobes", 32'({LD_PHASE, PHASE_MUX, LD_AMP, AMP_SEL, LD_TONE, TONE_MUX, ATT_ON, NOTE_ON}), 32'd0);
    do_init();

    run_frame(-1, 1'b0, 1'b0);

    send_event(60, 1'b1);
    att_t[60] = 1'b1;
    run_frame(-1, 1'b0, 1'b0);
    clr_tables();
    run_frame(-1, 1'b0, 1'b0);

    send_event(60, 1'b0);
    end_t[60] = 1'b1;
    run_frame(-1, 1'b0, 1'b0);
    clr_tables();
    run_frame(-1, 1'b0, 1'b0);

    send_event(5, 1'b1);
    run_frame(-1, 1'b0, 1'b0);
    end_t[5] = 1'b1;
    run_frame(5, 1'b1, 1'b0);
    clr_tables();
    run_frame(-1, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++) begin
      nev = int'($urandom_range(1, 6));
      for (int i = 0; i < nev; i++)
        send_event(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
      rand_tables();
      if ($urandom_range(0, 1) == 1)
        run_frame(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)), 1'b0);
      else
        run_frame(-1, 1'b0, 1'b0);
    end

    chk("overrun_before", 32'(OVERRUN), 32'd0);
    clr_tables();
    run_frame(-1, 1'b0, 1'b1);
    chk("overrun_after", 32'(OVERRUN), 32'd1);
    fd_seen = 0;
    for (int i = 0; i < 150; i++) begin
      if (FRAME_DONE) fd_seen++;
      step();
    end
    chk("no_extra_frame", 32'(fd_seen), 32'd0);
    chk("overrun_sticky", 32'(OVERRUN), 32'd1);

    // Abandon a frame mid-scan with reset; nothing from it may surface.
    send_event(77, 1'b1);
    mon_en      = 1'b0;
    SAMPLE_TICK = 1'b1;
    step();
    SAMPLE_TICK = 1'b0;
    repeat (40) step();
    RESET_N = 1'b0;
    #1;
    exp_q.delete();
    for (int k = 0; k < 128; k++) begin
      mst[k]   = IDLE;
      mgate[k] = 1'b0;
    end
    chk("midreset_overrun", 32'(OVERRUN), 32'd0);
    chk("midreset_voices", 32'(VOICES_ACTIVE), 32'd0);
    chk("midreset_key", 32'(KEY), 32'd0);
    chk("midreset_strobes", 32'({LD_PHASE, LD_AMP, LD_TONE, FRAME_DONE}), 32'd0);
    repeat (3) step();
    mon_en = 1'b1;
    do_init();
    run_frame(-1, 1'b0, 1'b0);

    repeat (5) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
